conv_dot_engine: RTL and testbench

Parametrised, pipelined, weight-stationary dot-product engine: multiplies LANES data elements by LANES stationary weights, reduces them through a registered adder tree, and accumulates across multiple beats, so a kernel longer than LANES is produced as one result. It replaces the fixed 4-lane, 8-bit convolution structure inside the convolution datapath. It adds a valid/ready handshake with backpressure, signed/unsigned mode, optional ReLU and an overflow flag.

---
 rtl/conv_dot_engine_pkg.sv | 22 ++
 rtl/conv_dot_engine_if.sv | 27 ++
 rtl/conv_dot_engine_adder_tree.sv | 57 +++++
 rtl/conv_dot_engine.sv | 81 ++++++++
 tb/tb_conv_dot_engine.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_dot_engine_pkg.sv
// conv_pkg: sizing helpers, beat sideband type and lane slicing macros for the convolution datapath
`ifndef CONV_LANE
`define CONV_LANE(v, i, w) v[(i)*(w) +: (w)]
`define CONV_LANE_MSB(v, i, w) v[(i)*(w)+(w)-1]
`endif
package conv_pkg;
   typedef struct packed {
      logic valid;
      logic last;
      logic sgn;
      logic relu;
   } beat_ctl_t;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic int acc_width(input int data_w, input int lanes, input int beats);
      return 2 * data_w + clog2(lanes) + clog2(beats);
   endfunction
endpackage

// File: rtl/conv_dot_engine_if.sv
// conv_dot_engine_if: beat input, weight load and result output handshake bundle
interface conv_dot_engine_if import conv_pkg::*; #(
   parameter int LANES = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W = acc_width(DATA_W, LANES, 16)
);
   logic                    weight_load;
   logic [LANES*DATA_W-1:0] weight_in;
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] data_in;
   logic                    in_last;
   logic                    signed_mode;
   logic                    relu_en;
   logic                    out_valid;
   logic                    out_ready;
   logic [ACC_W-1:0]        data_out;
   logic                    out_ovf;
   modport master (
      output weight_load, weight_in, in_valid, data_in, in_last, signed_mode, relu_en, out_ready,
      input  in_ready, out_valid, data_out, out_ovf
   );
   modport slave (
      input  weight_load, weight_in, in_valid, data_in, in_last, signed_mode, relu_en, out_ready,
      output in_ready, out_valid, data_out, out_ovf
   );
endinterface

// File: rtl/conv_dot_engine_adder_tree.sv
// dot_adder_tree: registered pairwise reduction of LANES operands, one level per cycle, widening one bit per level
module dot_adder_tree import conv_pkg::*; #(
   parameter int LANES = 4,
   parameter int IN_W = 16,
   localparam int L = clog2(LANES),
   localparam int OUT_W = IN_W + L
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [LANES*IN_W-1:0] in_data,
   input  beat_ctl_t             in_ctl,
   output logic [OUT_W-1:0]      sum,
   output beat_ctl_t             out_ctl
);
   // all levels live back to back in one flat vector; level l starts at offs(l)
   function automatic int offs(input int l);
      int o;
      o = 0;
      for (int j = 1; j < l; j++) o += (LANES >> j) * (IN_W + j);
      return o;
   endfunction
   localparam int TOT = offs(L + 1);
   logic [TOT-1:0] tree_d, tree_q;
   beat_ctl_t [L:1] ctl_d, ctl_q;
   beat_ctl_t [L:0] ctl_all;
   assign ctl_all = {ctl_q, in_ctl};
   assign ctl_d = en ? ctl_all[L-1:0] : ctl_q;
   for (genvar l = 1; l <= L; l++) begin : g_lvl
      localparam int W = IN_W + l;
      localparam int N = LANES >> l;
      logic [2*N*(W-1)-1:0] src;
      if (l == 1) begin : g_first
         assign src = in_data;
      end else begin : g_next
         assign src = tree_q[offs(l-1) +: 2*N*(W-1)];
      end
      for (genvar i = 0; i < N; i++) begin : g_node
         logic [W-2:0] a, b;
         assign a = `CONV_LANE(src, 2*i, W-1);
         assign b = `CONV_LANE(src, 2*i+1, W-1);
         assign tree_d[offs(l) + i*W +: W] = en ? {ctl_all[l-1].sgn & a[W-2], a} + {ctl_all[l-1].sgn & b[W-2], b}
                                               : tree_q[offs(l) + i*W +: W];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tree_q <= '0;
         ctl_q <= '0;
      end else begin
         tree_q <= tree_d;
         ctl_q <= ctl_d;
      end
   end
   assign sum = tree_q[offs(L) +: OUT_W];
   assign out_ctl = ctl_all[L];
endmodule

// File: rtl/conv_dot_engine.sv
// conv_dot_engine: weight-stationary pipelined dot product with multi-beat accumulation, ReLU and overflow flag
module conv_dot_engine import conv_pkg::*; #(
   parameter int LANES = 4,
   parameter int DATA_W = 8,
   parameter int ACC_BEATS_MAX = 16,
   localparam int L = clog2(LANES),
   localparam int ACC_W = acc_width(DATA_W, LANES, ACC_BEATS_MAX)
) (
   input logic clk,
   input logic reset,
   conv_dot_engine_if.slave bus
);
   localparam int PW = 2 * DATA_W;
   localparam int SW = PW + L;
   localparam int CW = clog2(ACC_BEATS_MAX) + 1;
   logic                    en, fire;
   logic [LANES*DATA_W-1:0] w_d, w_q, s0_data_d, s0_data_q;
   beat_ctl_t               s0_ctl_d, s0_ctl_q, s1_ctl_d, s1_ctl_q, t_ctl;
   logic [LANES*PW-1:0]     prod_d, prod_q;
   logic [PW-1:0]           a, b;
   logic [SW-1:0]           t_sum;
   logic [ACC_W-1:0]        total, acc_d, acc_q, dout_d, dout_q;
   logic [CW-1:0]           cnt_d, cnt_q;
   logic                    ovf_d, ovf_q, out_valid_d, out_valid_q;
   dot_adder_tree #(.LANES(LANES), .IN_W(PW)) u_tree (
      .clk(clk), .reset(reset), .en(en), .in_data(prod_q), .in_ctl(s1_ctl_q), .sum(t_sum), .out_ctl(t_ctl)
   );
   always_comb begin
      en = !(out_valid_q && !bus.out_ready);
      w_d = (en && bus.weight_load) ? bus.weight_in : w_q;
      s0_data_d = en ? bus.data_in : s0_data_q;
      s0_ctl_d = en ? '{valid: bus.in_valid, last: bus.in_last, sgn: bus.signed_mode, relu: bus.relu_en} : s0_ctl_q;
      s1_ctl_d = en ? s0_ctl_q : s1_ctl_q;
      prod_d = prod_q;
      a = '0;
      b = '0;
      // operands extended to the full product width so the low PW bits are exact in both modes
      for (int i = 0; i < LANES; i++) begin
         a = {{DATA_W{s0_ctl_q.sgn & `CONV_LANE_MSB(s0_data_q, i, DATA_W)}}, `CONV_LANE(s0_data_q, i, DATA_W)};
         b = {{DATA_W{s0_ctl_q.sgn & `CONV_LANE_MSB(w_q, i, DATA_W)}}, `CONV_LANE(w_q, i, DATA_W)};
         `CONV_LANE(prod_d, i, PW) = en ? a * b : `CONV_LANE(prod_q, i, PW);
      end
      fire = en && t_ctl.valid;
      total = acc_q + {{(ACC_W-SW){t_ctl.sgn & t_sum[SW-1]}}, t_sum};
      acc_d = fire ? (t_ctl.last ? '0 : total) : acc_q;
      cnt_d = fire ? (t_ctl.last ? '0 : cnt_q + CW'(cnt_q <= CW'(ACC_BEATS_MAX))) : cnt_q;
      dout_d = (fire && t_ctl.last) ? ((t_ctl.relu && t_ctl.sgn && total[ACC_W-1]) ? '0 : total) : dout_q;
      // cnt_q excludes the closing beat, so >= MAX means more than MAX beats in total
      ovf_d = (fire && t_ctl.last) ? (cnt_q >= CW'(ACC_BEATS_MAX)) : ovf_q;
      out_valid_d = (fire && t_ctl.last) ? 1'b1 : (out_valid_q && !bus.out_ready);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         w_q <= '0;
         s0_data_q <= '0;
         s0_ctl_q <= '0;
         prod_q <= '0;
         s1_ctl_q <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         dout_q <= '0;
         ovf_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         w_q <= w_d;
         s0_data_q <= s0_data_d;
         s0_ctl_q <= s0_ctl_d;
         prod_q <= prod_d;
         s1_ctl_q <= s1_ctl_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         dout_q <= dout_d;
         ovf_q <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign bus.in_ready = en;
   assign bus.out_valid = out_valid_q;
   assign bus.data_out = dout_q;
   assign bus.out_ovf = ovf_q;
endmodule

// File: tb/tb_conv_dot_engine.sv
// tb_conv_dot_engine: scoreboard bench; a behavioural model pushes expected results as beats are accepted
module tb_conv_dot_engine;
   localparam int LANES = 4;
   localparam int DATA_W = 8;
   localparam int ACC_W = 22;
   localparam int MAXB = 16;
   localparam int DW = LANES * DATA_W;
   typedef struct {
      logic [ACC_W-1:0] data;
      logic             ovf;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   exp_t q[$];
   logic [DW-1:0] mw;
   longint macc;
   int mcnt;
   conv_dot_engine_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
   conv_dot_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_BEATS_MAX(MAXB)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input longint got, input longint exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic logic [DW-1:0] pack(input logic [7:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction
   function automatic longint dot(input logic [DW-1:0] d, w, input logic sgn);
      longint s, x, y;
      logic [7:0] dx, wy;
      s = 0;
      for (int i = 0; i < LANES; i++) begin
         dx = d[i*8 +: 8];
         wy = w[i*8 +: 8];
         x = sgn ? longint'($signed(dx)) : longint'(dx);
         y = sgn ? longint'($signed(wy)) : longint'(wy);
         s += x * y;
      end
      return s;
   endfunction
   // one cycle of stimulus; the model follows the handshake the bench observes
   task automatic drive(input logic v, input logic [DW-1:0] d, w, input logic last, sgn, relu, wl, output logic took);
      exp_t e;
      bus.in_valid = v;
      bus.data_in = d;
      bus.weight_in = w;
      bus.in_last = last;
      bus.signed_mode = sgn;
      bus.relu_en = relu;
      bus.weight_load = wl;
      @(negedge clk);
      took = bus.in_ready;
      if (took) begin
         if (wl) mw = w;
         if (v) begin
            macc += dot(d, mw, sgn);
            mcnt++;
            if (last) begin
               e.data = macc[ACC_W-1:0];
               if (relu && sgn && e.data[ACC_W-1]) e.data = '0;
               e.ovf = mcnt > MAXB;
               q.push_back(e);
               macc = 0;
               mcnt = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.weight_load = 1'b0;
   endtask
   task automatic beat(input logic [DW-1:0] d, w, input logic last, sgn, relu, wl);
      logic took;
      int n;
      took = 1'b0;
      n = 0;
      while (!took && n < 50) begin
         drive(1'b1, d, w, last, sgn, relu, wl, took);
         n++;
      end
      if (!took) check("accept_timeout", took, 1);
   endtask
   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || bus.out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", q.size(), 0);
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) check("sb_depth", q.size(), 1);
         else begin
            e = q.pop_front();
            check("data_out", bus.data_out, e.data);
            check("out_ovf", bus.out_ovf, e.ovf);
         end
      end
   end
   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic took;
      logic [ACC_W-1:0] held;
      logic [DW-1:0] w0;
      int lat, n;
      bus.in_valid = 1'b0;
      bus.weight_load = 1'b0;
      bus.data_in = '0;
      bus.weight_in = '0;
      bus.in_last = 1'b0;
      bus.signed_mode = 1'b0;
      bus.relu_en = 1'b0;
      bus.out_ready = 1'b1;
      mw = '0;
      macc = 0;
      mcnt = 0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_data_out", bus.data_out, 0);
      check("rst_out_ovf", bus.out_ovf, 0);
      @(posedge clk);
      #1;
      // unsigned single beat and its latency
      beat(pack(10, 20, 30, 40), pack(1, 2, 3, 4), 1'b1, 1'b0, 1'b0, 1'b1);
      lat = 0;
      @(negedge clk);
      while (!bus.out_valid && lat < 20) begin
         lat++;
         @(negedge clk);
      end
      check("latency", lat, 4);
      check("single_beat_value", bus.data_out, 300);
      @(posedge clk);
      #1;
      // signed vs unsigned vs ReLU
      beat({4{8'hFF}}, {4{8'h02}}, 1'b1, 1'b1, 1'b0, 1'b1);
      beat({4{8'hFF}}, {4{8'h02}}, 1'b1, 1'b0, 1'b0, 1'b0);
      beat({4{8'hFF}}, {4{8'h02}}, 1'b1, 1'b1, 1'b1, 1'b0);
      drain();
      // multi-beat accumulation, then the overflow boundary at 16 and 17 beats
      beat({4{8'h01}}, {4{8'h01}}, 1'b0, 1'b0, 1'b0, 1'b1);
      beat({4{8'h01}}, {4{8'h01}}, 1'b0, 1'b0, 1'b0, 1'b0);
      beat({4{8'h01}}, {4{8'h01}}, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) beat({4{8'hFF}}, {4{8'hFF}}, i == 15, 1'b0, 1'b0, i == 0);
      for (int i = 0; i < 17; i++) beat({4{8'hFF}}, {4{8'hFF}}, i == 16, 1'b0, 1'b0, 1'b0);
      drain();
      // weight reload lands between two beats of one result
      beat({4{8'h01}}, {4{8'h01}}, 1'b0, 1'b0, 1'b0, 1'b1);
      beat({4{8'h01}}, {4{8'h02}}, 1'b1, 1'b0, 1'b0, 1'b1);
      drain();
      // weight load while stalled must be ignored
      bus.out_ready = 1'b0;
      beat({4{8'h01}}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("stall_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      drive(1'b0, '0, {4{8'h05}}, 1'b0, 1'b0, 1'b0, 1'b1, took);
      check("stall_wl_ready", took, 0);
      bus.out_ready = 1'b1;
      beat({4{8'h01}}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      drain();
      // backpressure on a continuous stream
      w0 = $urandom;
      fork
         begin
            for (int i = 0; i < 10; i++)
               beat($urandom, w0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i == 0);
         end
         begin
            n = 0;
            @(negedge clk);
            while (!bus.out_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            check("bp_first_valid", bus.out_valid, 1);
            repeat (2) @(negedge clk);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               check("bp_out_valid", bus.out_valid, 1);
               check("bp_in_ready", bus.in_ready, 0);
               if (j == 0) held = bus.data_out;
               else check("bp_hold", bus.data_out, held);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      // reset with an unfinished result in flight
      beat({4{8'h07}}, {4{8'h01}}, 1'b0, 1'b0, 1'b0, 1'b1);
      beat({4{8'h07}}, {4{8'h01}}, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      macc = 0;
      mcnt = 0;
      mw = '0;
      @(negedge clk);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      beat({4{8'h05}}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      beat({4{8'h03}}, {4{8'h01}}, 1'b1, 1'b0, 1'b0, 1'b1);
      drain();
      check("sb_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
